// File: rtl/ble_uart_rx_if.sv
// Handshake bundle between the BLE RX pin, the UART receiver and its consumer.
// slave = receiver side, master = pin driver / byte consumer side.
interface ble_uart_rx_if;
  logic       RX;
  logic       clr_rdy;
  logic [7:0] rx_data;
  logic       rdy;
  logic       frm_err;
  logic       ovr;

  modport slave  (input  RX, clr_rdy, output rx_data, rdy, frm_err, ovr);
  modport master (output RX, clr_rdy, input  rx_data, rdy, frm_err, ovr);
endinterface

// File: rtl/ble_uart_rx.sv
// 8N1 LSB-first UART receiver for the BLE command link, with rdy/clr_rdy
// handshake plus sticky framing-error and overrun flags.
//
// state | meaning
// IDLE  | line high, waiting for a falling edge on rx_s
// START | counting to mid start bit, re-checking it is still low
// DATA  | sampling 8 data bits at mid-bit
// STOP  | sampling the stop bit
// BRK   | bad stop bit; wait for the line to return high
module ble_uart_rx #(
  parameter int BAUD_DIV = 5208
) (
  input  logic         clk,
  input  logic         rst,
  ble_uart_rx_if.slave bus
);

  localparam logic [12:0] HALF_LOAD = 13'(BAUD_DIV / 2);
  localparam logic [12:0] FULL_LOAD = 13'(BAUD_DIV - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  state_t      state;
  logic        rx_ff1;
  logic        rx_s;
  logic [12:0] baud_cnt;
  logic [3:0]  bit_cnt;
  logic [7:0]  shift;
  logic        tick;

  assign tick = (baud_cnt == 13'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_ff1      <= 1'b1;
      rx_s        <= 1'b1;
      state       <= IDLE;
      baud_cnt    <= HALF_LOAD;
      bit_cnt     <= 4'd0;
      shift       <= 8'h00;
      bus.rx_data <= 8'h00;
      bus.rdy     <= 1'b0;
      bus.frm_err <= 1'b0;
      bus.ovr     <= 1'b0;
    end else begin
      rx_ff1   <= bus.RX;
      rx_s     <= rx_ff1;
      baud_cnt <= tick ? FULL_LOAD : baud_cnt - 13'd1;

      // A completing good frame below overrides this clear (set wins).
      if (bus.clr_rdy) begin
        bus.rdy <= 1'b0;
        bus.ovr <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (!rx_s) begin
            state    <= START;
            baud_cnt <= HALF_LOAD;
          end
        end
        START: begin
          if (tick) begin
            if (rx_s) begin
              state <= IDLE;
            end else begin
              state   <= DATA;
              bit_cnt <= 4'd0;
            end
          end
        end
        DATA: begin
          if (tick) begin
            shift   <= {rx_s, shift[7:1]};
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) state <= STOP;
          end
        end
        STOP: begin
          if (tick) begin
            if (rx_s) begin
              bus.rx_data <= shift;
              bus.rdy     <= 1'b1;
              bus.frm_err <= 1'b0;
              bus.ovr     <= bus.rdy & ~bus.clr_rdy;
              state       <= IDLE;
            end else begin
              bus.frm_err <= 1'b1;
              state       <= BRK;
            end
          end
        end
        BRK: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ble_uart_rx.sv
// Bench for ble_uart_rx: directed handshake/error scenarios followed by random
// frames, all compared against a frame-level model of the receiver outputs.
module tb_ble_uart_rx;
  localparam int BAUD_DIV = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  ble_uart_rx_if bus();

  ble_uart_rx #(.BAUD_DIV(BAUD_DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int lat    = 156;

  // Frame-level model of what the consumer should see.
  logic [7:0] exp_data;
  logic       exp_rdy;
  logic       exp_frm;
  logic       exp_ovr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/rx_data"}, 32'(bus.rx_data), 32'(exp_data));
    chk({tag, "/rdy"},     32'(bus.rdy),     32'(exp_rdy));
    chk({tag, "/frm_err"}, 32'(bus.frm_err), 32'(exp_frm));
    chk({tag, "/ovr"},     32'(bus.ovr),     32'(exp_ovr));
  endtask

  task automatic model_reset();
    exp_data = 8'h00; exp_rdy = 1'b0; exp_frm = 1'b0; exp_ovr = 1'b0;
  endtask

  task automatic model_good(input logic [7:0] b);
    exp_ovr  = exp_rdy;
    exp_rdy  = 1'b1;
    exp_data = b;
    exp_frm  = 1'b0;
  endtask

  task automatic model_clr();
    exp_rdy = 1'b0;
    exp_ovr = 1'b0;
  endtask

  task automatic idle_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called on a negedge; returns on the negedge that ends the stop bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    bus.RX = 1'b0;
    idle_clks(BAUD_DIV);
    for (int i = 0; i < 8; i++) begin
      bus.RX = b[i];
      idle_clks(BAUD_DIV);
    end
    bus.RX = stop_bit;
    idle_clks(BAUD_DIV);
  endtask

  task automatic pulse_clr();
    bus.clr_rdy = 1'b1;
    @(negedge clk);
    bus.clr_rdy = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.RX      = 1'b1;
    bus.clr_rdy = 1'b0;
    model_reset();
    idle_clks(3);
    check_all("reset");
    rst = 1'b0;
    idle_clks(4);
    check_all("reset_rel");

    // Single byte with latency measurement, then clear.
    fork
      send_frame(8'h67, 1'b1);
      begin
        int n = 0;
        while (!bus.rdy && n < 400) begin
          @(posedge clk);
          #1;
          n++;
        end
        lat = n;
      end
    join
    chk("t1_latency", 32'(lat >= 153 && lat <= 157), 32'd1);
    model_good(8'h67);
    check_all("t1_byte");
    bus.clr_rdy = 1'b1;
    @(posedge clk);
    #1;
    chk("t1_clr_next_clk", 32'(bus.rdy), 32'd0);
    @(negedge clk);
    bus.clr_rdy = 1'b0;
    model_clr();
    check_all("t1_cleared");
    pulse_clr();
    check_all("t1_clr_idle");

    // Back-to-back frames without clearing -> overrun.
    send_frame(8'h73, 1'b1);
    model_good(8'h73);
    send_frame(8'h66, 1'b1);
    model_good(8'h66);
    check_all("t2_overrun");
    pulse_clr();
    model_clr();
    check_all("t2_cleared");

    // Short low glitch is ignored.
    bus.RX = 1'b0;
    idle_clks(4);
    bus.RX = 1'b1;
    idle_clks(30);
    check_all("t3_glitch");

    // Bad stop bit, line held low, then recovery with a good frame.
    send_frame(8'hA5, 1'b0);
    idle_clks(40);
    exp_frm = 1'b1;
    check_all("t4_frm_err");
    bus.RX = 1'b1;
    idle_clks(8);
    send_frame(8'h5A, 1'b1);
    model_good(8'h5A);
    check_all("t4_recover");

    // Reset during data bit 4 of 0xFF; remainder of the frame is discarded.
    fork
      send_frame(8'hFF, 1'b1);
    join_none
    idle_clks(BAUD_DIV + 4 * BAUD_DIV + BAUD_DIV / 2);
    rst = 1'b1;
    #1;
    model_reset();
    check_all("t5_rst_async");
    idle_clks(2);
    rst = 1'b0;
    wait fork;
    idle_clks(5);
    check_all("t5_discard");
    send_frame(8'h67, 1'b1);
    model_good(8'h67);
    check_all("t5_after_rst");

    // clr_rdy on the very edge the stop bit is sampled (rdy already set).
    fork
      send_frame(8'h67, 1'b1);
      begin
        repeat (lat - 1) @(posedge clk);
        @(negedge clk);
        bus.clr_rdy = 1'b1;
        @(negedge clk);
        bus.clr_rdy = 1'b0;
      end
    join
    model_clr();
    model_good(8'h67);
    check_all("t6_set_wins");

    // Random traffic.
    for (int k = 0; k < 30; k++) begin
      logic [7:0] b;
      logic       bad;
      if ($urandom_range(0, 5) == 0) begin
        bus.RX = 1'b0;
        idle_clks($urandom_range(1, 6));
        bus.RX = 1'b1;
        idle_clks(20);
      end
      if ($urandom_range(0, 2) == 0) begin
        pulse_clr();
        model_clr();
      end
      b   = 8'($urandom);
      bad = ($urandom_range(0, 6) == 0);
      send_frame(b, ~bad);
      if (bad) begin
        exp_frm = 1'b1;
        idle_clks($urandom_range(5, 30));
        bus.RX = 1'b1;
        idle_clks(6);
      end else begin
        model_good(b);
      end
      check_all($sformatf("rand%0d", k));
      idle_clks($urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
